// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous single-port SRAM between a CPU port (A,
// read/write) and a video/fetch port (B, read-only). Each access is sequenced
// IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> DONE so that the address and
// data are stable around the enable and write strobes.
// Optional build macro: SRAM_ARB_RR_EN selects round-robin arbitration instead
// of fixed B priority.
module sram_arbiter #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned WAIT_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_ack,
  output logic [DATA_BITS-1:0] a_rdata,
  input  logic                 b_req,
  input  logic [ADDR_BITS-1:0] b_addr,
  output logic                 b_ack,
  output logic [DATA_BITS-1:0] b_rdata,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  output logic                 ram_nen,
  output logic                 ram_nwe,
  input  logic [DATA_BITS-1:0] ram_dout
);

  localparam int unsigned CNT_BITS = 4;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_BITS-1:0] ram_din_q, ram_din_d;
  logic                 ram_nen_q, ram_nen_d;
  logic                 ram_nwe_q, ram_nwe_d;
  logic                 a_ack_q, a_ack_d;
  logic                 b_ack_q, b_ack_d;
  logic [DATA_BITS-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_BITS-1:0] b_rdata_q, b_rdata_d;
  logic                 busy_q, busy_d;
  logic                 grant_b;

  // Arbitration between the two requesters, only consulted in IDLE.
  always_comb begin
    grant_b = b_req;
`ifdef SRAM_ARB_RR_EN
    // Contention goes to the port that did not own the previous access.
    if (a_req && b_req) begin
      grant_b = (owner_q == OWN_A);
    end
`endif
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          owner_d    = grant_b ? OWN_B : OWN_A;
          ram_addr_d = grant_b ? b_addr : a_addr;
          ram_din_d  = grant_b ? '0 : a_wdata;
          we_d       = grant_b ? 1'b0 : a_we;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (owner_q == OWN_B) begin
              b_rdata_d = ram_dout;
            end else begin
              a_rdata_d = ram_dout;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and acks are decoded from the state being entered so they
    // leave the flops aligned with that state.
    ram_nen_d = !((state_d == S_SETUP) || (state_d == S_ACCESS));
    ram_nwe_d = !((state_d == S_ACCESS) && we_d);
    a_ack_d   = (state_d == S_DONE) && (owner_d == OWN_A);
    b_ack_d   = (state_d == S_DONE) && (owner_d == OWN_B);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers; reset parks the SRAM disabled.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_A;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_nen_q  <= 1'b1;
      ram_nwe_q  <= 1'b1;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_nen_q  <= ram_nen_d;
      ram_nwe_q  <= ram_nwe_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = busy_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_nen  = ram_nen_q;
  assign ram_nwe  = ram_nwe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a behavioural SRAM, a bus-protocol monitor, a table
// of single transactions, hand-written multi-cycle sequences and a randomized
// phase checked against a transaction-level arbitration/latency model.
module tb_sram_arbiter;

  localparam int unsigned W  = 2;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;
  localparam int unsigned RAND_CYC = 3000;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic          a_req, a_we, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack, b_ack, busy, ram_nen, ram_nwe;
  logic [DW-1:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  sram_arbiter #(.DATA_BITS(DW), .ADDR_BITS(AW), .WAIT_CYC(W)) dut (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_nen(ram_nen), .ram_nwe(ram_nwe), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous SRAM model: combinational read, write while both strobes low.
  logic [DW-1:0] sram [2048];
  logic          tb_started = 1'b0;
  assign ram_dout = sram[ram_addr];
  always @(posedge clk) begin
    if (!tb_started) begin
      for (int i = 0; i < 2048; i++) sram[i] <= '0;
    end else if (!ram_nen && !ram_nwe) begin
      sram[ram_addr] <= ram_din;
    end
  end

  // Bus protocol monitor.
  logic          mon_prev_low = 1'b0;
  logic [AW-1:0] mon_addr;
  logic [DW-1:0] mon_din;
  always @(negedge clk) begin
    if (nreset === 1'b1) begin
      if (!ram_nwe) check("nwe_without_nen", 32'(ram_nen), 32'd0);
      if (a_ack || b_ack) check("ack_overlap", 32'(a_ack & b_ack), 32'd0);
      if (!ram_nen && mon_prev_low) begin
        check("addr_stable", 32'(ram_addr), 32'(mon_addr));
        check("din_stable", 32'(ram_din), 32'(mon_din));
      end
    end
    mon_prev_low = (nreset === 1'b1) && !ram_nen;
    mon_addr     = ram_addr;
    mon_din      = ram_din;
  end

  typedef struct {
    logic          port_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [8];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;

  // One isolated transaction: latency, strobe widths, busy width and read data.
  task automatic run_txn(input vec_t v, input string tag);
    int n, nen_lo, nwe_lo, busy_n;
    bit got;
    @(negedge clk);
    if (v.port_b) begin
      b_req = 1'b1; b_addr = v.addr;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    n = 0; nen_lo = 0; nwe_lo = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!ram_nen) nen_lo++;
      if (!ram_nwe) nwe_lo++;
      if (busy) busy_n++;
      if (v.port_b ? b_ack : a_ack) begin
        got = 1'b1; a_req = 1'b0; b_req = 1'b0;
      end
    end
    check({tag, "_ack_latency"}, 32'(n), 32'(W + 2));
    check({tag, "_nen_low_cycles"}, 32'(nen_lo), 32'(W + 1));
    check({tag, "_nwe_low_cycles"}, 32'(nwe_lo), v.we ? 32'(W) : 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W + 2));
    if (!v.we) begin
      if (v.port_b) exp_b = v.exp_rd; else exp_a = v.exp_rd;
    end
    check({tag, "_a_rdata"}, 32'(a_rdata), 32'(exp_a));
    check({tag, "_b_rdata"}, 32'(b_rdata), 32'(exp_b));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'({a_ack, b_ack}), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nen"}, 32'(ram_nen), 32'd1);
    check({tag, "_nwe"}, 32'(ram_nwe), 32'd1);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_din"}, 32'(ram_din), 32'd0);
    check({tag, "_acks"}, 32'({a_ack, b_ack}), 32'd0);
    check({tag, "_rdata"}, 32'({a_rdata, b_rdata}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Transaction-level model state for the randomized phase.
  logic [DW-1:0] ref_mem [2048];
  int            e, free_edge, ack_edge;
  bit            txn_act, txn_b, txn_we, last_b, pick_b, a_pend, b_pend;
  bit            x_ack_a, x_ack_b, x_busy;
  logic [DW-1:0] txn_rd;
  logic [AW-1:0] g_addr;
  int            ea, eb, n_a, n_b, last_i, k, n_ack;

  initial begin
    nreset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;

    tbl[0] = '{1'b0, 1'b1, 11'h123, 8'h5A, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 11'h123, 8'h00, 8'h5A};
    tbl[2] = '{1'b1, 1'b0, 11'h123, 8'h00, 8'h5A};
    tbl[3] = '{1'b0, 1'b1, 11'h7FF, 8'hA5, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 11'h7FF, 8'h00, 8'hA5};
    tbl[5] = '{1'b0, 1'b1, 11'h001, 8'hC3, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 11'h001, 8'h00, 8'hC3};
    tbl[7] = '{1'b1, 1'b0, 11'h000, 8'h00, 8'h00};

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    tb_started = 1'b1;
    nreset = 1'b1;

    // Randomized traffic against the transaction-level model.
    e = 0; free_edge = 0; ack_edge = 0; txn_act = 1'b0; txn_b = 1'b0;
    txn_we = 1'b0; txn_rd = '0; last_b = 1'b0; a_pend = 1'b0; b_pend = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < int'(RAND_CYC); cyc++) begin
      if ((e + 1) >= free_edge && (a_req || b_req)) begin
        if (a_req && b_req) pick_b = RR ? !last_b : 1'b1;
        else                pick_b = b_req;
        last_b    = pick_b;
        txn_b     = pick_b;
        txn_act   = 1'b1;
        ack_edge  = e + 1 + int'(W) + 1;
        free_edge = e + 1 + int'(W) + 3;
        txn_we    = pick_b ? 1'b0 : a_we;
        g_addr    = pick_b ? b_addr : a_addr;
        txn_rd    = ref_mem[g_addr];
        if (txn_we) ref_mem[g_addr] = a_wdata;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
      x_ack_a = txn_act && (e == ack_edge) && !txn_b;
      x_ack_b = txn_act && (e == ack_edge) && txn_b;
      x_busy  = txn_act && (e <= ack_edge) && (e >= ack_edge - int'(W) - 1);
      if (x_ack_a && !txn_we) exp_a = txn_rd;
      if (x_ack_b) exp_b = txn_rd;
      check("rnd_a_ack", 32'(a_ack), 32'(x_ack_a));
      check("rnd_b_ack", 32'(b_ack), 32'(x_ack_b));
      check("rnd_busy", 32'(busy), 32'(x_busy));
      check("rnd_a_rdata", 32'(a_rdata), 32'(exp_a));
      check("rnd_b_rdata", 32'(b_rdata), 32'(exp_b));
      if (x_ack_a) a_pend = 1'b0;
      if (x_ack_b) b_pend = 1'b0;
      if (!a_pend && cyc < int'(RAND_CYC) - 30 && $urandom_range(0, 3) == 0) begin
        a_pend = 1'b1; a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
        a_addr = 11'h200 | AW'($urandom & 32'h40F); a_wdata = DW'($urandom);
      end else if (!a_pend) begin
        a_req = 1'b0;
      end
      if (!b_pend && cyc < int'(RAND_CYC) - 30 && $urandom_range(0, 3) == 0) begin
        b_pend = 1'b1; b_req = 1'b1;
        b_addr = 11'h200 | AW'($urandom & 32'h40F);
      end else if (!b_pend) begin
        b_req = 1'b0;
      end
    end

    // Reset pulse between phases restores owner A and clears read data.
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    nreset = 1'b1;
    exp_a = '0; exp_b = '0;

    // Table of isolated transactions.
    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Simultaneous requests, previous owner B.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h000;
    b_req = 1'b1; b_addr = 11'h123;
    ea = -1; eb = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ack) begin ea = i; a_req = 1'b0; end
      if (b_ack) begin eb = i; b_req = 1'b0; end
    end
    check("sim_a_ack_edge", 32'(ea), RR ? 32'(W + 2) : 32'(2 * W + 5));
    check("sim_b_ack_edge", 32'(eb), RR ? 32'(2 * W + 5) : 32'(W + 2));
    check("sim_b_rdata", 32'(b_rdata), 32'h5A);
    check("sim_a_rdata", 32'(a_rdata), 32'h00);
    exp_a = 8'h00; exp_b = 8'h5A;

    // Both requests held high continuously.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h001;
    b_req = 1'b1; b_addr = 11'h123;
    n_a = 0; n_b = 0; last_i = -1; k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ack || b_ack) begin
        if (last_i >= 0) check("hold_ack_spacing", 32'(i - last_i), 32'(W + 3));
        check("hold_ack_port", 32'(b_ack), RR ? 32'(k % 2) : 32'd1);
        last_i = i; k++;
        if (a_ack) n_a++;
        if (b_ack) n_b++;
      end
    end
    check("hold_a_acks", 32'(n_a), RR ? 32'd6 : 32'd0);
    check("hold_b_acks", 32'(n_b), RR ? 32'd6 : 32'd12);
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) @(negedge clk);
    exp_b = 8'h5A;
    if (RR) exp_a = 8'hC3;

    // Reset asserted during ACCESS of an A write.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h055; a_wdata = 8'h77;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_access_nwe_low", 32'(ram_nwe), 32'd0);
    #1 nreset = 1'b0;
    #1;
    check_reset_outputs("rst_access");
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    exp_a = '0; exp_b = '0;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ack || b_ack || busy) n_ack++;
    end
    check("rst_access_no_activity", 32'(n_ack), 32'd0);

    // A write whose request drops during SETUP still completes.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h0AA; a_wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    check("drop_setup_busy", 32'(busy), 32'd1);
    a_req = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ack) n_ack++;
    end
    check("drop_setup_acks", 32'(n_ack), 32'd1);
    run_txn('{1'b0, 1'b0, 11'h0AA, 8'h00, 8'h3C}, "drop_readback");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
